// File: rtl/cv32e40p_obi_arbiter.sv
// Round-robin OBI arbiter: N manager ports share one subordinate port.
// An in-order ID FIFO routes each response back to the port that issued the request.
module cv32e40p_obi_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_PORTS-1:0]                   m_req_i,
    output logic [NUM_PORTS-1:0]                   m_gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_PORTS-1:0]                   m_we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_PORTS-1:0]                   m_rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   m_rdata_o,
    output logic                                   s_req_o,
    input  logic                                   s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  s_addr_o,
    output logic                                   s_we_o,
    output logic [DATA_WIDTH/8-1:0]                s_be_o,
    output logic [DATA_WIDTH-1:0]                  s_wdata_o,
    input  logic                                   s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = DATA_WIDTH / 8;

    logic [PW-1:0]        ptr_r;
    logic                 lock_r;
    logic [PW-1:0]        lock_port_r;
    logic [PW-1:0]        id_fifo_r [MAX_OUTSTANDING];
    logic [IW-1:0]        wr_ptr_r;
    logic [IW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 err_r;

    logic                 low_found_s;
    logic [PW-1:0]        low_port_s;
    logic                 high_found_s;
    logic [PW-1:0]        high_port_s;
    logic [PW-1:0]        sel_s;
    logic                 sel_valid_s;
    logic                 has_space_s;
    logic                 s_req_s;
    logic                 hs_s;
    logic                 pop_s;
    logic                 stray_s;
    logic [PW-1:0]        head_s;
    logic [NUM_PORTS-1:0] sel_hit_s;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] port);
        return (port == PW'(NUM_PORTS - 1)) ? {PW{1'b0}} : port + PW'(1);
    endfunction

    function automatic logic [IW-1:0] next_slot(input logic [IW-1:0] slot);
        return (slot == IW'(MAX_OUTSTANDING - 1)) ? {IW{1'b0}} : slot + IW'(1);
    endfunction

    // Round-robin pick: first requester at or above ptr, else lowest requester (wrap).
    always_comb begin
        low_found_s  = 1'b0;
        low_port_s   = {PW{1'b0}};
        high_found_s = 1'b0;
        high_port_s  = {PW{1'b0}};
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            low_port_s   = m_req_i[p] ? PW'(p) : low_port_s;
            low_found_s  = low_found_s | m_req_i[p];
            high_port_s  = (m_req_i[p] && (PW'(p) >= ptr_r)) ? PW'(p) : high_port_s;
            high_found_s = high_found_s | (m_req_i[p] && (PW'(p) >= ptr_r));
        end
    end

    // A pending unaccepted request keeps its port selected until the handshake.
    assign sel_s       = lock_r ? lock_port_r : (high_found_s ? high_port_s : low_port_s);
    assign sel_valid_s = ~rst_i & (lock_r | low_found_s);
    assign has_space_s = (count_r < CW'(MAX_OUTSTANDING));
    assign s_req_s     = sel_valid_s & has_space_s;
    assign hs_s        = s_req_s & s_gnt_i;
    assign head_s      = id_fifo_r[rd_ptr_r];
    assign pop_s       = ~rst_i & s_rvalid_i & (count_r != {CW{1'b0}});
    assign stray_s     = ~rst_i & s_rvalid_i & (count_r == {CW{1'b0}});

    // Address-phase mux and grant decode for the selected port.
    always_comb begin
        m_gnt_o   = {NUM_PORTS{1'b0}};
        sel_hit_s = {NUM_PORTS{1'b0}};
        s_addr_o  = {ADDR_WIDTH{1'b0}};
        s_we_o    = 1'b0;
        s_be_o    = {BW{1'b0}};
        s_wdata_o = {DATA_WIDTH{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_hit_s[p] = sel_valid_s & (sel_s == PW'(p));
            m_gnt_o[p]   = sel_hit_s[p] & hs_s;
            s_addr_o     = s_addr_o  | ({ADDR_WIDTH{sel_hit_s[p]}} & m_addr_i[p]);
            s_we_o       = s_we_o    | (sel_hit_s[p] & m_we_i[p]);
            s_be_o       = s_be_o    | ({BW{sel_hit_s[p]}} & m_be_i[p]);
            s_wdata_o    = s_wdata_o | ({DATA_WIDTH{sel_hit_s[p]}} & m_wdata_i[p]);
        end
    end

    // Response routing to the port at the FIFO head.
    always_comb begin
        m_rvalid_o = {NUM_PORTS{1'b0}};
        m_rdata_o  = {(NUM_PORTS * DATA_WIDTH){1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            m_rvalid_o[p] = pop_s & (head_s == PW'(p));
            m_rdata_o[p]  = {DATA_WIDTH{pop_s & (head_s == PW'(p))}} & s_rdata_i;
        end
    end

    // Priority pointer and address-phase lock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r       <= {PW{1'b0}};
            lock_r      <= 1'b0;
            lock_port_r <= {PW{1'b0}};
        end else if (hs_s) begin
            ptr_r  <= next_port(sel_s);
            lock_r <= 1'b0;
        end else if (s_req_s) begin
            lock_r      <= 1'b1;
            lock_port_r <= sel_s;
        end
    end

    // ID FIFO storage and pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {IW{1'b0}};
            rd_ptr_r <= {IW{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo_r[i] <= {PW{1'b0}};
            end
        end else begin
            if (hs_s) begin
                id_fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r            <= next_slot(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_slot(rd_ptr_r);
            end
        end
    end

    // In-flight counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({hs_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (stray_s) begin
            err_r <= 1'b1;
        end
    end

    assign s_req_o       = s_req_s;
    assign outstanding_o = count_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
// Directed scenario tasks plus a randomized run against a queue-based
// reference model of the arbiter (round robin, lock, in-order responses).
module tb_cv32e40p_obi_arbiter;

    localparam int NP = 2;
    localparam int MO = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MO + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          m_req, m_gnt, m_we, m_rvalid;
    logic [NP-1:0][AW-1:0]  m_addr;
    logic [NP-1:0][BW-1:0]  m_be;
    logic [NP-1:0][DW-1:0]  m_wdata, m_rdata;
    logic                   s_req, s_gnt, s_we, s_rvalid;
    logic [AW-1:0]          s_addr;
    logic [BW-1:0]          s_be;
    logic [DW-1:0]          s_wdata, s_rdata;
    logic [CW-1:0]          outstanding;
    logic                   err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int  md_ptr;
    bit  md_lock;
    int  md_lock_port;
    int  md_q[$];
    bit  md_err;
    // reference model predictions
    bit            e_any, e_sreq, e_hs;
    int            e_sel;
    logic [NP-1:0] e_gnt, e_rv;
    int            e_head;

    cv32e40p_obi_arbiter #(
        .NUM_PORTS(NP), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
        .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        m_req    = '0;
        m_we     = '0;
        m_be     = '0;
        m_wdata  = '0;
        m_addr[0] = 32'h0000_1000;
        m_addr[1] = 32'h0000_2000;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    task automatic model_reset();
        md_ptr = 0; md_lock = 0; md_lock_port = 0; md_err = 0;
        md_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Predict combinational outputs from the current model state and inputs.
    task automatic model_eval();
        e_any = md_lock || (m_req != '0);
        e_sel = 0;
        if (md_lock) e_sel = md_lock_port;
        else begin
            for (int k = NP - 1; k >= 0; k--)
                if (m_req[(md_ptr + k) % NP]) e_sel = (md_ptr + k) % NP;
        end
        e_sreq = e_any && (md_q.size() < MO);
        e_hs   = e_sreq && s_gnt;
        e_gnt  = e_hs ? NP'(1 << e_sel) : '0;
        e_head = (md_q.size() > 0) ? md_q[0] : -1;
        e_rv   = (s_rvalid && e_head >= 0) ? NP'(1 << e_head) : '0;
    endtask

    // Advance the model across one rising edge.
    task automatic model_commit();
        int pre;
        pre = md_q.size();
        if (s_rvalid && pre > 0) void'(md_q.pop_front());
        if (s_rvalid && pre == 0) md_err = 1;
        if (e_hs) begin
            md_q.push_back(e_sel);
            md_ptr  = (e_sel + 1) % NP;
            md_lock = 0;
        end else if (e_sreq) begin
            md_lock      = 1;
            md_lock_port = e_sel;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #2;
        n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL reset_sreq got %b want 0", s_req); end
        n_checks++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", m_gnt); end
        n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", m_rvalid); end
        n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", s_addr); end
        n_checks++; if (m_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", m_rdata); end
        apply_reset();
    endtask

    task automatic test_alternate();
        logic [NP-1:0] eg, er;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            m_req = 2'b11; s_gnt = 1'b1; s_rvalid = (k > 0); s_rdata = 32'hD0 + k;
            #1;
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++; if (m_gnt !== eg) begin n_fail++; $display("FAIL alt_gnt[%0d] got %b want %b", k, m_gnt, eg); end
            n_checks++; if (outstanding !== ((k == 0) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL alt_outstanding[%0d] got %0d", k, outstanding); end
            if (k > 0) begin
                er = (k % 2 == 1) ? 2'b01 : 2'b10;
                n_checks++; if (m_rvalid !== er) begin n_fail++; $display("FAIL alt_rvalid[%0d] got %b want %b", k, m_rvalid, er); end
                n_checks++; if (m_rdata[(k + 1) % 2] !== 32'hD0 + k) begin n_fail++; $display("FAIL alt_rdata[%0d] got %h want %h", k, m_rdata[(k + 1) % 2], 32'hD0 + k); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        m_req = 2'b01; s_gnt = 1'b1;
        #1;
        n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL lock_pre_gnt got %b want 01", m_gnt); end
        @(negedge clk);
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h55;
        #1;
        n_checks++; if (m_rvalid !== 2'b01 || m_rdata[0] !== 32'h55) begin n_fail++; $display("FAIL lock_pre_resp got %b/%h want 01/55", m_rvalid, m_rdata[0]); end
        @(negedge clk);
        s_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_req = (c == 0) ? 2'b01 : 2'b11; s_gnt = 1'b0;
            #1;
            n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h1000) begin n_fail++; $display("FAIL lock_hold[%0d] got req=%b addr=%h want 1/1000", c, s_req, s_addr); end
            n_checks++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL lock_nognt[%0d] got %b want 00", c, m_gnt); end
            @(negedge clk);
        end
        m_req = 2'b11; s_gnt = 1'b1;
        #1;
        n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL lock_release got %b want 01", m_gnt); end
        @(negedge clk);
        m_req = 2'b10;
        #1;
        n_checks++; if (m_gnt !== 2'b10 || s_addr !== 32'h2000) begin n_fail++; $display("FAIL lock_next got %b/%h want 10/2000", m_gnt, s_addr); end
        @(negedge clk);
    endtask

    task automatic test_full();
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            m_req = 2'b01; s_gnt = 1'b1;
            #1;
            n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL full_gnt[%0d] got %b want 01", c, m_gnt); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (outstanding !== 2'd2 || s_req !== 1'b0 || m_gnt !== 2'b00) begin n_fail++; $display("FAIL full_block got out=%0d req=%b gnt=%b want 2/0/00", outstanding, s_req, m_gnt); end
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'h77;
        #1;
        n_checks++; if (m_rvalid !== 2'b01 || s_req !== 1'b0) begin n_fail++; $display("FAIL full_nobypass got rv=%b req=%b want 01/0", m_rvalid, s_req); end
        @(negedge clk);
        s_rvalid = 1'b0; s_gnt = 1'b0;
        #1;
        n_checks++; if (outstanding !== 2'd1 || s_req !== 1'b1) begin n_fail++; $display("FAIL full_reopen got out=%0d req=%b want 1/1", outstanding, s_req); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] rq  [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
        logic [NP-1:0] rv  [4] = '{2'b00, 2'b10, 2'b01, 2'b10};
        logic [DW-1:0] dat [4] = '{32'h0, 32'hA, 32'hB, 32'hC};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            m_req = rq[c]; s_gnt = 1'b1; s_rvalid = (c > 0); s_rdata = dat[c];
            #1;
            n_checks++; if (m_gnt !== rq[c]) begin n_fail++; $display("FAIL b2b_gnt[%0d] got %b want %b", c, m_gnt, rq[c]); end
            n_checks++; if (m_rvalid !== rv[c]) begin n_fail++; $display("FAIL b2b_rvalid[%0d] got %b want %b", c, m_rvalid, rv[c]); end
            if (c > 0) begin
                n_checks++; if (m_rdata[(c == 2) ? 0 : 1] !== dat[c]) begin n_fail++; $display("FAIL b2b_rdata[%0d] got %h want %h", c, m_rdata[(c == 2) ? 0 : 1], dat[c]); end
                n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL b2b_outstanding[%0d] got %0d want 1", c, outstanding); end
            end
            @(negedge clk);
        end
        s_rvalid = 1'b0;
        #1;
        n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL b2b_drained got %0d want 0", outstanding); end
        @(negedge clk);
    endtask

    task automatic test_stray_response();
        apply_reset();
        s_rvalid = 1'b1; s_rdata = 32'h99;
        #1;
        n_checks++; if (m_rvalid !== 2'b00 || err !== 1'b0) begin n_fail++; $display("FAIL stray_pulse got rv=%b err=%b want 00/0", m_rvalid, err); end
        @(negedge clk);
        s_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (err !== 1'b1 || outstanding !== 2'd0) begin n_fail++; $display("FAIL stray_sticky[%0d] got err=%b out=%0d want 1/0", c, err, outstanding); end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stray_clear got %b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        m_req = 2'b11; s_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL areset_pre got %0d want 2", outstanding); end
        #2;
        rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234;
        #1;
        n_checks++; if (outstanding !== 2'd0 || s_req !== 1'b0 || m_gnt !== 2'b00) begin n_fail++; $display("FAIL areset_now got out=%0d req=%b gnt=%b want 0/0/00", outstanding, s_req, m_gnt); end
        n_checks++; if (m_rvalid !== 2'b00 || s_addr !== 32'h0 || m_rdata !== '0) begin n_fail++; $display("FAIL areset_data got rv=%b addr=%h want 00/0", m_rvalid, s_addr); end
        @(negedge clk);
        rst = 1'b0; m_req = 2'b00; s_gnt = 1'b0;
        #1;
        n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL areset_stray_rv got %b want 00", m_rvalid); end
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL areset_err got %b want 1", err); end
        @(negedge clk);
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            m_req = NP'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                m_addr[p]  = $urandom;
                m_wdata[p] = $urandom;
                m_be[p]    = BW'($urandom_range(0, 15));
                m_we[p]    = 1'($urandom_range(0, 1));
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = ($urandom_range(0, 2) == 0);
            s_rdata  = $urandom;
            #1;
            model_eval();
            n_checks++; if (s_req !== e_sreq) begin n_fail++; $display("FAIL rnd_sreq[%0d] got %b want %b", c, s_req, e_sreq); end
            n_checks++; if (m_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, m_gnt, e_gnt); end
            n_checks++; if (m_rvalid !== e_rv) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got %b want %b", c, m_rvalid, e_rv); end
            n_checks++; if (outstanding !== CW'(md_q.size())) begin n_fail++; $display("FAIL rnd_outstanding[%0d] got %0d want %0d", c, outstanding, md_q.size()); end
            n_checks++; if (err !== md_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", c, err, md_err); end
            if (e_sreq) begin
                n_checks++;
                if (s_addr !== m_addr[e_sel] || s_we !== m_we[e_sel] || s_be !== m_be[e_sel] || s_wdata !== m_wdata[e_sel]) begin
                    n_fail++; $display("FAIL rnd_mux[%0d] got addr=%h want %h (port %0d)", c, s_addr, m_addr[e_sel], e_sel);
                end
            end
            if (!e_any) begin
                n_checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin n_fail++; $display("FAIL rnd_idle_mux[%0d] got %h want 0", c, s_addr); end
            end
            if (e_rv != '0) begin
                n_checks++; if (m_rdata[e_head] !== s_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h want %h", c, m_rdata[e_head], s_rdata); end
            end
            if (e_head >= 0) begin
                n_checks++; if (m_rdata[1 - e_head] !== 32'h0) begin n_fail++; $display("FAIL rnd_rdata_other[%0d] got %h want 0", c, m_rdata[1 - e_head]); end
            end
            model_commit();
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_back_to_back();
        test_stray_response();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_obi_arbiter.md
CV32E40P_OBI_ARBITER -- requirements
Module: cv32e40p_obi_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of OBI manager ports (legal 2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered transactions (legal 1..8).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width (multiple of 8).
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous active-high reset
REQ-005 SHALL have manager-side ports, one element per port p:
- m_req_i  in  NUM_PORTS  request
- m_gnt_o  out  NUM_PORTS  grant
- m_addr_i  in  NUM_PORTS x ADDR_WIDTH  address
- m_we_i  in  NUM_PORTS  write enable
- m_be_i  in  NUM_PORTS x DATA_WIDTH/8  byte enables
- m_wdata_i  in  NUM_PORTS x DATA_WIDTH  write data
- m_rvalid_o  out  NUM_PORTS  response valid
- m_rdata_o  out  NUM_PORTS x DATA_WIDTH  read data
REQ-006 SHALL have subordinate-side ports: s_req_o out 1; s_gnt_i in 1; s_addr_o out ADDR_WIDTH; s_we_o out 1; s_be_o out DATA_WIDTH/8; s_wdata_o out DATA_WIDTH; s_rvalid_i in 1; s_rdata_i in DATA_WIDTH.
REQ-007 SHALL have status ports: outstanding_o out clog2(MAX_OUTSTANDING+1) current in-flight count; err_o out 1 sticky unexpected-response flag.

Function
REQ-008 Address handshake for port p SHALL occur in a cycle where s_req_o=1, s_gnt_i=1 and selected port = p; m_gnt_o[p] = s_req_o & s_gnt_i & (sel==p), purely combinational, all other m_gnt_o bits 0.
REQ-009 Selection SHALL be round-robin: among ports with m_req_i=1, pick the first at or after priority pointer ptr (wrapping NUM_PORTS-1 -> 0).
REQ-010 After each address handshake on port p, ptr SHALL become (p+1) mod NUM_PORTS on the next edge; ptr unchanged otherwise.
REQ-011 Lock: once s_req_o=1 for port p without s_gnt_i, sel SHALL stay p on following cycles until handshake, regardless of other requests (OBI address-phase stability); lock clears on handshake.
REQ-012 s_addr_o, s_we_o, s_be_o, s_wdata_o SHALL mux the selected port's inputs; all zero when no port is selected.
REQ-013 s_req_o SHALL be 1 iff some port requests (or lock active) and count < MAX_OUTSTANDING; when full, s_req_o=0 and lock state is held; no same-cycle pop-to-push bypass.
REQ-014 Each handshake SHALL push the port index into an ID FIFO of depth MAX_OUTSTANDING; each s_rvalid_i with count>0 SHALL pop the head.
REQ-015 Response routing SHALL be combinational, zero latency: m_rvalid_o[head]=s_rvalid_i, m_rdata_o[head]=s_rdata_i; all other ports rvalid=0, rdata=0.
REQ-016 Simultaneous push and pop SHALL keep count unchanged and preserve FIFO order; pointers wrap modulo MAX_OUTSTANDING.
REQ-017 s_rvalid_i=1 with count=0 SHALL be ignored (no m_rvalid_o, count stays 0) and set err_o=1 from the next cycle until reset.
REQ-018 Responses SHALL be returned strictly in request order; no reordering.

Reset
REQ-019 While rst_i=1: count=0, FIFO empty, ptr=0, lock cleared, err_o=0; outputs s_req_o=0, all m_gnt_o=0, all m_rvalid_o=0, outstanding_o=0, data outputs 0.
REQ-020 Reset asserted mid-transaction SHALL discard all in-flight entries; a later s_rvalid_i is treated per REQ-017.

Verification
REQ-021 NUM_PORTS=2: m_req_i=2'b11 each cycle, s_gnt_i=1, s_rvalid_i one cycle after each grant -> grants alternate port0, port1, port0...; each rvalid routed to issuing port.
REQ-022 Port0 requests, s_gnt_i=0 for 3 cycles while port1 then requests -> sel stays 0, s_addr_o stable 3 cycles, port0 granted on cycle 4, port1 next.
REQ-023 MAX_OUTSTANDING=2, s_rvalid_i held 0 -> two handshakes, outstanding_o=2, s_req_o=0; one s_rvalid_i -> outstanding_o=1, s_req_o=1 next cycle.
REQ-024 Issue p1,p0,p1 back to back, responses rdata 0xA,0xB,0xC -> p1 gets 0xA, p0 gets 0xB, p1 gets 0xC; simultaneous push/pop keeps outstanding_o constant.
REQ-025 s_rvalid_i pulse with outstanding_o=0 -> no m_rvalid_o, err_o=1 next cycle and held; rst_i pulse -> err_o=0.
REQ-026 Assert rst_i with 2 outstanding -> outputs per REQ-019 immediately (asynchronous); post-reset s_rvalid_i sets err_o.
